// File: rtl/pipe_stage_chain.sv
// Elastic N-stage pipeline register chain with per-stage skid buffers,
// synchronous flush, occupancy tracking and a saturating stall counter.
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1,
    parameter int CNT_W = 16,
    localparam int OCC_W = $clog2(2 * STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic [STAGES-1:0] r_main_v;
    logic [STAGES-1:0] r_skid_v;
    logic [DATA_W-1:0] r_main [STAGES];
    logic [DATA_W-1:0] r_skid [STAGES];
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_stall;

    logic [STAGES-1:0] w_up_v;
    logic [STAGES-1:0] w_dn_rdy;
    logic [STAGES-1:0] w_acc;
    logic [STAGES-1:0] w_adv;
    logic [DATA_W-1:0] w_up_d [STAGES];
    logic              w_in_fire;
    logic              w_out_fire;

    // Each stage sees the previous main register as its upstream and the
    // next stage's registered "skid empty" as its downstream ready.
    assign w_up_v[0] = in_valid;
    assign w_up_d[0] = in_data;
    assign w_dn_rdy[STAGES-1] = out_ready;

    generate
        for (genvar g = 1; g < STAGES; g++) begin : g_link
            assign w_up_v[g] = r_main_v[g-1];
            assign w_up_d[g] = r_main[g-1];
            assign w_dn_rdy[g-1] = ~r_skid_v[g];
        end
    endgenerate

    assign w_acc = w_up_v & ~r_skid_v;
    assign w_adv = ~r_main_v | w_dn_rdy;

    assign in_ready = ~r_skid_v[0];
    assign out_valid = r_main_v[STAGES-1];
    assign out_data = r_main[STAGES-1];
    assign occupancy = r_occ;
    assign stall_cycles = r_stall;

    assign w_in_fire = in_valid & ~r_skid_v[0];
    assign w_out_fire = r_main_v[STAGES-1] & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_v <= '0;
            r_skid_v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_main[i] <= '0;
                r_skid[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    if (r_skid_v[i]) begin
                        r_main[i]   <= r_skid[i];
                        r_main_v[i] <= 1'b1;
                        r_skid_v[i] <= 1'b0;
                    end else begin
                        r_main_v[i] <= w_acc[i];
                        if (w_acc[i]) r_main[i] <= w_up_d[i];
                    end
                end else if (w_acc[i]) begin
                    r_skid[i]   <= w_up_d[i];
                    r_skid_v[i] <= 1'b1;
                end
            end
            // Squash only drops valid bits; payload registers keep stale data.
            if (flush) begin
                r_main_v <= '0;
                r_skid_v <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_fire, w_out_fire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && !(&r_stall)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed + random bench for pipe_stage_chain with a FIFO scoreboard
// and immediate-assertion checks on every sampled output.
module tb_pipe_stage_chain;

    localparam int DW = 32;
    localparam int ST = 3;
    localparam int CW = 4;
    localparam int OW = $clog2(2 * ST + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] sb_exp;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_d;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .DATA_W(DW),
        .STAGES(ST),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on input transfer, pop on output transfer.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) begin
                n_vec++;
                assert (out_data === hold_d) else begin
                    n_err++;
                    $error("FAIL hold: got %0h expected %0h", out_data, hold_d);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $error("FAIL sb_extra: got %0h expected none", out_data);
                end else begin
                    sb_exp = q.pop_front();
                    n_pop++;
                    assert (out_data === sb_exp) else begin
                        n_err++;
                        $error("FAIL sb_data: got %0h expected %0h",
                               out_data, sb_exp);
                    end
                end
            end
            hold_pend = out_valid && !out_ready && !flush;
            hold_d = out_data;
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pop0;
        int exp_occ;
        int a;
        int o;
        logic pend;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_occ", 64'(occupancy), 64'(0));
        chk("rst_stall", 64'(stall_cycles), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;

        // Stream 1..16 back to back; word driven in cycle j is out in j+3.
        for (int i = 0; i < 20; i++) begin
            chk("st_out_valid", 64'(out_valid), 64'(i >= 3 && i < 19));
            if (i >= 3 && i < 19)
                chk("st_out_data", 64'(out_data), 64'(i - 2));
            a = (i < 16) ? i : 16;
            o = (i < 3) ? 0 : ((i - 3 > 16) ? 16 : i - 3);
            chk("st_occ", 64'(occupancy), 64'(a - o));
            if (i < 16) chk("st_in_ready", 64'(in_ready), 64'(1));
            chk("st_stall", 64'(stall_cycles), 64'(0));
            out_ready = 1'b1;
            in_valid = (i < 16);
            in_data = DW'(i + 1);
            @(negedge clk);
        end
        chk("st_pops", 64'(n_pop), 64'(16));

        // Full backpressure: chain holds 2*ST words, stall saturates at 15.
        acc = 0;
        for (int i = 0; i < 22; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'(i < 2 * ST));
            chk("bp_occ", 64'(occupancy), 64'((i < 2 * ST) ? i : 2 * ST));
            chk("bp_out_valid", 64'(out_valid), 64'(i >= 3));
            if (i >= 3) chk("bp_out_data", 64'(out_data), 64'('h100));
            chk("bp_stall", 64'(stall_cycles),
                64'((i < 3) ? 0 : ((i - 3 > 15) ? 15 : i - 3)));
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_data = DW'('h100 + acc);
            if (in_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepts", 64'(acc), 64'(2 * ST));
        pop0 = n_pop;
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("bp_drained", 64'(n_pop - pop0), 64'(2 * ST));
        chk("bp_occ_end", 64'(occupancy), 64'(0));
        chk("bp_valid_end", 64'(out_valid), 64'(0));
        chk("bp_stall_hold", 64'(stall_cycles), 64'(15));

        // Flush while an output transfer completes and 0xDEAD is offered.
        pop0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                chk("fl_out_valid", 64'(out_valid), 64'(1));
                chk("fl_out_data", 64'(out_data), 64'('h202));
                chk("fl_occ", 64'(occupancy), 64'(3));
            end
            if (i == 5) begin
                chk("fl_post_valid", 64'(out_valid), 64'(0));
                chk("fl_post_occ", 64'(occupancy), 64'(0));
                chk("fl_post_ready", 64'(in_ready), 64'(1));
            end
            if (i > 5) chk("fl_quiet", 64'(out_valid), 64'(0));
            out_ready = 1'b1;
            in_valid = (i <= 4);
            in_data = (i == 4) ? DW'('hDEAD) : DW'('h201 + i);
            flush = (i == 4);
            @(negedge clk);
        end
        chk("fl_pops", 64'(n_pop - pop0), 64'(2));
        chk("fl_stall_kept", 64'(stall_cycles), 64'(15));

        // Random valid/ready with upstream holding offered data.
        pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            exp_occ = q.size();
            chk("rnd_occ_sb", 64'(occupancy), 64'(exp_occ));
            chk("rnd_occ_max", 64'(occupancy <= OW'(2 * ST)), 64'(1));
            if (!pend) begin
                in_valid = ($urandom_range(1) == 1);
                in_data = $urandom;
            end
            out_ready = ($urandom_range(1) == 1);
            pend = in_valid && !in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("rnd_sb_empty", 64'(q.size()), 64'(0));
        chk("rnd_occ_end", 64'(occupancy), 64'(0));

        // Fill, then reset together with flush.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'('h300 + i);
            @(negedge clk);
            if (!in_ready) break;
        end
        repeat (4) @(negedge clk);
        chk("rf_full_occ", 64'(occupancy), 64'(2 * ST));
        rst_n = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("rf_out_valid", 64'(out_valid), 64'(0));
        chk("rf_out_data", 64'(out_data), 64'(0));
        chk("rf_occ", 64'(occupancy), 64'(0));
        chk("rf_stall", 64'(stall_cycles), 64'(0));
        chk("rf_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 6; i++) begin
            chk("rf_lat_valid", 64'(out_valid), 64'(i == 3));
            if (i == 3) chk("rf_lat_data", 64'(out_data), 64'('h77));
            out_ready = 1'b1;
            in_valid = (i == 0);
            in_data = DW'('h77);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
